lc3b_instr_encoder: RTL and testbench
=====================================

// Module: lc3b_instr_encoder
// PURPOSE
//  Packs decoded LC-3b instruction fields into 16-bit instruction words and
//  writes them into memory one at a time at consecutive word addresses.
//  It is the inverse of the datapath's instruction-register field split.
//  Used by the program-loader/self-test path to build instruction streams in
//  memory. Upstream is a valid/ready field source; downstream is the standard
//  mem_* port with a mem_resp handshake.
// PARAMETERS
//  RESET_ADDR  16'h0000  write address after reset
//  ADDR_STEP   2         byte increment per written word
// PORTS
//  clk            in   1   clock; all state changes on posedge
//  rst_n          in   1   asynchronous active-low reset
//  in_valid       in   1   field bundle valid
//  in_ready       out  1   encoder can accept a bundle
//  opcode         in   4   lc3b_opcode
//  dest           in   3   DR, or nzp for BR
//  src1           in   3   SR1 or BaseR
//  src2           in   3   SR2
//  imm            in   11  generic immediate: imm5/off6/off9/off11/imm4/trapvect
//  flag_a         in   1   imm-select for ADD/AND; JSR-vs-JSRR; SHF A bit
//  flag_b         in   1   SHF D bit
//  addr_load      in   1   load addr_in as next write address (IDLE only)
//  addr_in        in   16  new write address; bit0 ignored and forced 0
//  mem_address    out  16  write address
//  mem_wdata      out  16  encoded instruction word
//  mem_write      out  1   write request, held until mem_resp
//  mem_byte_enable out 2   always 2'b11 while mem_write is high, else 2'b00
//  mem_resp       in   1   write complete
//  wr_done        out  1   1-cycle pulse: a word was written
//  range_err      out  1   1-cycle pulse: bundle rejected, immediate out of range
//  word_count     out  16  words written since reset; wraps 16'hFFFF->0
// BEHAVIOUR
//  Reset: state IDLE; addr=RESET_ADDR; mem_write=0; mem_wdata=0; wr_done=0;
//   range_err=0; word_count=0. Async, so mem_write drops immediately even mid-write.
//  FSM: IDLE, WRITE.
//   in_ready = (state==IDLE) && !addr_load. When addr_load is high in IDLE, the
//   address loads and no bundle is accepted in that cycle. addr_load is ignored in WRITE.
//   IDLE, in_valid&&in_ready, in range: register the word; go to WRITE on the next edge.
//    mem_write is high starting in the next cycle.
//   IDLE, accepted, out of range: no write; range_err pulses in the next cycle;
//    stay in IDLE; addr and word_count unchanged.
//   WRITE: hold mem_write, mem_address and mem_wdata stable until mem_resp.
//    On the mem_resp edge: go to IDLE; addr += ADDR_STEP (mod 2^16, so 16'hFFFE->0);
//    word_count += 1; wr_done pulses in the next cycle. in_ready is high that cycle.
//    mem_resp is ignored in IDLE.
//  Encoding: [15:12] = opcode. Reserved bits are always 0.
//   ADD/AND: DR,SR1; flag_a=1 -> [5]=1, [4:0]=imm5; else [5:3]=000, [2:0]=SR2
//   NOT: DR,SR1, [5:0]=6'h3F.      BR: [11:9]=nzp, [8:0]=off9.   LEA: DR, off9
//   LDB/LDR/LDI/STB/STR/STI: DR(SR), BaseR, off6
//   JMP: [11:9]=0, BaseR, [5:0]=0
//   JSR (flag_a=1): [11]=1, [10:0]=off11
//   JSRR (flag_a=0): [11:9]=0, BaseR, [5:0]=0
//   SHF: DR, SR1, [5]=flag_a, [4]=flag_b, [3:0]=imm4
//   TRAP: [11:8]=0, [7:0]=trapvect.       RTI: [11:0]=0
//  Range check (only where the field is used):
//   signed N-bit fields (imm5, off6, off9): imm[10:N-1] must be all-equal.
//   unsigned fields (imm4, trapvect): imm[10:N] must be 0. off11 always fits.
// TESTING
//  ADD R1,R2,#-3 (flag_a=1, imm=11'h7FD) at 0x0000 -> mem_wdata 16'h12BD,
//   mem_write from acceptance+1, wr_done after resp, next addr 0x0002
//  NOT R3,R4 then TRAP x25 back-to-back -> 16'h973F at 0x0000, 16'hF025 at 0x0002,
//   word_count=2
//  JSR off11=-1 -> 16'h4FFF; SHF R1,R1,#3 A=1,D=1 -> 16'hD273
//  ADD imm=16 (flag_a=1) -> range_err pulse, no mem_write, addr/word_count unchanged
//  addr_load 0xFFFF then two writes -> addresses 0xFFFE then 0x0000
//   (mem_resp delayed 5 cycles; outputs stable while waiting)
//  rst_n low during WRITE -> mem_write 0 at once; after release, addr=RESET_ADDR,
//   in_ready=1

Source files
------------

// File: rtl/lc3b_instr_encoder.sv
// Packs LC-3b instruction fields into 16-bit words and writes them to consecutive addresses.
// Latency: mem_write rises 1 cycle after acceptance; in_ready is low for the whole write (until mem_resp).
module lc3b_instr_encoder #(
   parameter logic [15:0] RESET_ADDR = 16'h0000,
   parameter logic [15:0] ADDR_STEP  = 16'd2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  opcode,
   input  logic [2:0]  dest,
   input  logic [2:0]  src1,
   input  logic [2:0]  src2,
   input  logic [10:0] imm,
   input  logic        flag_a,
   input  logic        flag_b,
   input  logic        addr_load,
   input  logic [15:0] addr_in,
   output logic [15:0] mem_address,
   output logic [15:0] mem_wdata,
   output logic        mem_write,
   output logic [1:0]  mem_byte_enable,
   input  logic        mem_resp,
   output logic        wr_done,
   output logic        range_err,
   output logic [15:0] word_count
);

   localparam logic [3:0] OP_BR   = 4'b0000;
   localparam logic [3:0] OP_ADD  = 4'b0001;
   localparam logic [3:0] OP_LDB  = 4'b0010;
   localparam logic [3:0] OP_STB  = 4'b0011;
   localparam logic [3:0] OP_JSR  = 4'b0100;
   localparam logic [3:0] OP_AND  = 4'b0101;
   localparam logic [3:0] OP_LDR  = 4'b0110;
   localparam logic [3:0] OP_STR  = 4'b0111;
   localparam logic [3:0] OP_RTI  = 4'b1000;
   localparam logic [3:0] OP_NOT  = 4'b1001;
   localparam logic [3:0] OP_LDI  = 4'b1010;
   localparam logic [3:0] OP_STI  = 4'b1011;
   localparam logic [3:0] OP_JMP  = 4'b1100;
   localparam logic [3:0] OP_SHF  = 4'b1101;
   localparam logic [3:0] OP_LEA  = 4'b1110;
   localparam logic [3:0] OP_TRAP = 4'b1111;

   typedef enum logic {S_IDLE, S_WRITE} state_t;

   state_t      state_q, state_d;
   logic [15:0] addr_q, addr_d;
   logic [15:0] wdata_q, wdata_d;
   logic        wr_done_q, wr_done_d;
   logic        range_err_q, range_err_d;
   logic [15:0] count_q, count_d;

   logic [15:0] enc_word;
   logic        enc_ok;
   logic        accept;

   // Signed fields fit when all bits above the sign bit replicate it.
   logic imm5_ok, off6_ok, off9_ok, imm4_ok, trap_ok;
   assign imm5_ok = (&imm[10:4]) | ~(|imm[10:4]);
   assign off6_ok = (&imm[10:5]) | ~(|imm[10:5]);
   assign off9_ok = (&imm[10:8]) | ~(|imm[10:8]);
   assign imm4_ok = ~(|imm[10:4]);
   assign trap_ok = ~(|imm[10:8]);

   always_comb begin
      enc_word = {opcode, 12'h000};
      enc_ok   = 1'b1;
      unique case (opcode)
         OP_ADD, OP_AND: begin
            if (flag_a) begin
               enc_word[11:0] = {dest, src1, 1'b1, imm[4:0]};
               enc_ok         = imm5_ok;
            end else begin
               enc_word[11:0] = {dest, src1, 3'b000, src2};
            end
         end
         OP_NOT: enc_word[11:0] = {dest, src1, 6'h3F};
         OP_BR, OP_LEA: begin
            enc_word[11:0] = {dest, imm[8:0]};
            enc_ok         = off9_ok;
         end
         OP_LDB, OP_LDR, OP_LDI, OP_STB, OP_STR, OP_STI: begin
            enc_word[11:0] = {dest, src1, imm[5:0]};
            enc_ok         = off6_ok;
         end
         OP_JMP: enc_word[11:0] = {3'b000, src1, 6'h00};
         OP_JSR: begin
            if (flag_a) enc_word[11:0] = {1'b1, imm[10:0]};
            else        enc_word[11:0] = {3'b000, src1, 6'h00};
         end
         OP_SHF: begin
            enc_word[11:0] = {dest, src1, flag_a, flag_b, imm[3:0]};
            enc_ok         = imm4_ok;
         end
         OP_TRAP: begin
            enc_word[11:0] = {4'h0, imm[7:0]};
            enc_ok         = trap_ok;
         end
         OP_RTI: enc_word[11:0] = 12'h000;
         default: enc_word[11:0] = 12'h000;
      endcase
   end

   assign in_ready = (state_q == S_IDLE) && !addr_load;
   assign accept   = in_valid && in_ready;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wr_done_d   = 1'b0;
      range_err_d = 1'b0;
      count_d     = count_q;
      unique case (state_q)
         S_IDLE: begin
            if (addr_load) begin
               addr_d = {addr_in[15:1], 1'b0};
            end else if (accept) begin
               if (enc_ok) begin
                  wdata_d = enc_word;
                  state_d = S_WRITE;
               end else begin
                  range_err_d = 1'b1;
               end
            end
         end
         S_WRITE: begin
            if (mem_resp) begin
               state_d   = S_IDLE;
               addr_d    = addr_q + ADDR_STEP;
               count_d   = count_q + 16'd1;
               wr_done_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         addr_q      <= RESET_ADDR;
         wdata_q     <= 16'h0000;
         wr_done_q   <= 1'b0;
         range_err_q <= 1'b0;
         count_q     <= 16'h0000;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wr_done_q   <= wr_done_d;
         range_err_q <= range_err_d;
         count_q     <= count_d;
      end
   end

   assign mem_write       = (state_q == S_WRITE);
   assign mem_byte_enable = {2{mem_write}};
   assign mem_address     = addr_q;
   assign mem_wdata       = wdata_q;
   assign wr_done         = wr_done_q;
   assign range_err       = range_err_q;
   assign word_count      = count_q;

endmodule

// File: tb/tb_lc3b_instr_encoder.sv
// Directed bench for lc3b_instr_encoder: encodings, handshake timing, range errors, address wrap, reset.
module tb_lc3b_instr_encoder;

   localparam logic [3:0] OP_BR   = 4'b0000;
   localparam logic [3:0] OP_ADD  = 4'b0001;
   localparam logic [3:0] OP_STB  = 4'b0011;
   localparam logic [3:0] OP_JSR  = 4'b0100;
   localparam logic [3:0] OP_AND  = 4'b0101;
   localparam logic [3:0] OP_LDR  = 4'b0110;
   localparam logic [3:0] OP_RTI  = 4'b1000;
   localparam logic [3:0] OP_NOT  = 4'b1001;
   localparam logic [3:0] OP_JMP  = 4'b1100;
   localparam logic [3:0] OP_SHF  = 4'b1101;
   localparam logic [3:0] OP_LEA  = 4'b1110;
   localparam logic [3:0] OP_TRAP = 4'b1111;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  opcode;
   logic [2:0]  dest, src1, src2;
   logic [10:0] imm;
   logic        flag_a, flag_b;
   logic        addr_load;
   logic [15:0] addr_in;
   logic [15:0] mem_address;
   logic [15:0] mem_wdata;
   logic        mem_write;
   logic [1:0]  mem_byte_enable;
   logic        mem_resp;
   logic        wr_done;
   logic        range_err;
   logic [15:0] word_count;

   int checks = 0;
   int errors = 0;

   logic [15:0] exp_addr;
   logic [15:0] exp_cnt;

   typedef struct {
      logic [3:0]  op;
      logic [2:0]  d, s1, s2;
      logic [10:0] im;
      logic        fa, fb;
      logic [15:0] word;
   } vec_t;

   vec_t good_vecs[11];
   vec_t bad_vecs[6];

   lc3b_instr_encoder dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .opcode         (opcode),
      .dest           (dest),
      .src1           (src1),
      .src2           (src2),
      .imm            (imm),
      .flag_a         (flag_a),
      .flag_b         (flag_b),
      .addr_load      (addr_load),
      .addr_in        (addr_in),
      .mem_address    (mem_address),
      .mem_wdata      (mem_wdata),
      .mem_write      (mem_write),
      .mem_byte_enable(mem_byte_enable),
      .mem_resp       (mem_resp),
      .wr_done        (wr_done),
      .range_err      (range_err),
      .word_count     (word_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] op, input logic [2:0] d, input logic [2:0] s1,
                        input logic [2:0] s2, input logic [10:0] im, input logic fa, input logic fb);
      opcode = op; dest = d; src1 = s1; src2 = s2; imm = im; flag_a = fa; flag_b = fb;
   endtask

   // Presents one bundle for a single cycle; caller must be in IDLE.
   task automatic offer(input logic [3:0] op, input logic [2:0] d, input logic [2:0] s1,
                        input logic [2:0] s2, input logic [10:0] im, input logic fa, input logic fb);
      drive(op, d, s1, s2, im, fa, fb);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   // Waits `delay` cycles checking the write is held stable, then completes it.
   task automatic respond(input int delay, input logic [15:0] a, input logic [15:0] w);
      for (int i = 0; i < delay; i++) begin
         tick();
         chk("hold_write", {15'd0, mem_write}, 16'd1);
         chk("hold_addr", mem_address, a);
         chk("hold_data", mem_wdata, w);
      end
      mem_resp = 1'b1;
      tick();
      mem_resp = 1'b0;
   endtask

   initial begin
      good_vecs[0]  = '{OP_JSR, 3'd0, 3'd0, 3'd0, 11'h7FF, 1'b1, 1'b0, 16'h4FFF};
      good_vecs[1]  = '{OP_SHF, 3'd1, 3'd1, 3'd0, 11'h003, 1'b1, 1'b1, 16'hD273};
      good_vecs[2]  = '{OP_JSR, 3'd0, 3'd5, 3'd0, 11'h000, 1'b0, 1'b0, 16'h4140};
      good_vecs[3]  = '{OP_LDR, 3'd2, 3'd3, 3'd0, 11'h7FF, 1'b0, 1'b0, 16'h64FF};
      good_vecs[4]  = '{OP_BR,  3'd7, 3'd0, 3'd0, 11'h7FE, 1'b0, 1'b0, 16'h0FFE};
      good_vecs[5]  = '{OP_ADD, 3'd1, 3'd2, 3'd3, 11'h010, 1'b0, 1'b0, 16'h1283};
      good_vecs[6]  = '{OP_STB, 3'd7, 3'd0, 3'd0, 11'h01F, 1'b0, 1'b0, 16'h3E1F};
      good_vecs[7]  = '{OP_AND, 3'd0, 3'd0, 3'd0, 11'h00F, 1'b1, 1'b0, 16'h502F};
      good_vecs[8]  = '{OP_RTI, 3'd7, 3'd7, 3'd7, 11'h7FF, 1'b1, 1'b1, 16'h8000};
      good_vecs[9]  = '{OP_JMP, 3'd5, 3'd7, 3'd2, 11'h7FF, 1'b0, 1'b0, 16'hC1C0};
      good_vecs[10] = '{OP_LEA, 3'd6, 3'd0, 3'd0, 11'h0FF, 1'b0, 1'b0, 16'hECFF};

      bad_vecs[0] = '{OP_ADD,  3'd1, 3'd2, 3'd0, 11'h010, 1'b1, 1'b0, 16'h0000};
      bad_vecs[1] = '{OP_AND,  3'd1, 3'd2, 3'd0, 11'h7EF, 1'b1, 1'b0, 16'h0000};
      bad_vecs[2] = '{OP_LEA,  3'd1, 3'd0, 3'd0, 11'h100, 1'b0, 1'b0, 16'h0000};
      bad_vecs[3] = '{OP_TRAP, 3'd0, 3'd0, 3'd0, 11'h100, 1'b0, 1'b0, 16'h0000};
      bad_vecs[4] = '{OP_SHF,  3'd1, 3'd1, 3'd0, 11'h010, 1'b1, 1'b0, 16'h0000};
      bad_vecs[5] = '{OP_LDR,  3'd1, 3'd1, 3'd0, 11'h020, 1'b0, 1'b0, 16'h0000};

      rst_n = 1'b0; in_valid = 1'b0; addr_load = 1'b0; addr_in = 16'h0000; mem_resp = 1'b0;
      drive(4'h0, 3'd0, 3'd0, 3'd0, 11'h000, 1'b0, 1'b0);
      #12 rst_n = 1'b1;
      tick();

      chk("rst_in_ready", {15'd0, in_ready}, 16'd1);
      chk("rst_mem_write", {15'd0, mem_write}, 16'd0);
      chk("rst_be", {14'd0, mem_byte_enable}, 16'd0);
      chk("rst_addr", mem_address, 16'h0000);
      chk("rst_wdata", mem_wdata, 16'h0000);
      chk("rst_wr_done", {15'd0, wr_done}, 16'd0);
      chk("rst_range_err", {15'd0, range_err}, 16'd0);
      chk("rst_count", word_count, 16'h0000);

      // ADD R1,R2,#-3 with a 2-cycle memory response
      offer(OP_ADD, 3'd1, 3'd2, 3'd0, 11'h7FD, 1'b1, 1'b0);
      chk("add_write", {15'd0, mem_write}, 16'd1);
      chk("add_be", {14'd0, mem_byte_enable}, 16'h0003);
      chk("add_in_ready", {15'd0, in_ready}, 16'd0);
      chk("add_wdata", mem_wdata, 16'h12BD);
      chk("add_addr", mem_address, 16'h0000);
      respond(2, 16'h0000, 16'h12BD);
      chk("add_wr_done", {15'd0, wr_done}, 16'd1);
      chk("add_write_low", {15'd0, mem_write}, 16'd0);
      chk("add_be_low", {14'd0, mem_byte_enable}, 16'd0);
      chk("add_ready_again", {15'd0, in_ready}, 16'd1);
      chk("add_next_addr", mem_address, 16'h0002);
      chk("add_count", word_count, 16'h0001);
      tick();
      chk("add_done_pulse", {15'd0, wr_done}, 16'd0);

      // mem_resp in IDLE has no effect
      mem_resp = 1'b1;
      tick();
      mem_resp = 1'b0;
      chk("idle_resp_addr", mem_address, 16'h0002);
      chk("idle_resp_done", {15'd0, wr_done}, 16'd0);
      chk("idle_resp_cnt", word_count, 16'h0001);

      rst_n = 1'b0;
      #2 rst_n = 1'b1;
      tick();
      chk("rst2_addr", mem_address, 16'h0000);
      chk("rst2_count", word_count, 16'h0000);

      // NOT R3,R4 then TRAP x25 back-to-back
      offer(OP_NOT, 3'd3, 3'd4, 3'd0, 11'h000, 1'b0, 1'b0);
      chk("not_wdata", mem_wdata, 16'h973F);
      chk("not_addr", mem_address, 16'h0000);
      respond(0, 16'h0000, 16'h973F);
      chk("not_ready", {15'd0, in_ready}, 16'd1);
      offer(OP_TRAP, 3'd0, 3'd0, 3'd0, 11'h025, 1'b0, 1'b0);
      chk("trap_wdata", mem_wdata, 16'hF025);
      chk("trap_addr", mem_address, 16'h0002);
      respond(0, 16'h0002, 16'hF025);
      chk("b2b_count", word_count, 16'h0002);
      chk("b2b_addr", mem_address, 16'h0004);

      exp_addr = 16'h0004;
      exp_cnt  = 16'h0002;
      foreach (good_vecs[i]) begin
         offer(good_vecs[i].op, good_vecs[i].d, good_vecs[i].s1, good_vecs[i].s2,
               good_vecs[i].im, good_vecs[i].fa, good_vecs[i].fb);
         chk($sformatf("enc%0d_word", i), mem_wdata, good_vecs[i].word);
         chk($sformatf("enc%0d_addr", i), mem_address, exp_addr);
         respond(0, exp_addr, good_vecs[i].word);
         exp_addr = exp_addr + 16'd2;
         exp_cnt  = exp_cnt + 16'd1;
      end
      chk("enc_count", word_count, exp_cnt);
      chk("enc_addr", mem_address, exp_addr);

      foreach (bad_vecs[i]) begin
         offer(bad_vecs[i].op, bad_vecs[i].d, bad_vecs[i].s1, bad_vecs[i].s2,
               bad_vecs[i].im, bad_vecs[i].fa, bad_vecs[i].fb);
         chk($sformatf("rng%0d_err", i), {15'd0, range_err}, 16'd1);
         chk($sformatf("rng%0d_nowrite", i), {15'd0, mem_write}, 16'd0);
         chk($sformatf("rng%0d_addr", i), mem_address, exp_addr);
         chk($sformatf("rng%0d_cnt", i), word_count, exp_cnt);
         tick();
         chk($sformatf("rng%0d_pulse", i), {15'd0, range_err}, 16'd0);
         chk($sformatf("rng%0d_still", i), {15'd0, mem_write}, 16'd0);
      end

      // Address load wins over a valid bundle; bit 0 is dropped
      drive(OP_ADD, 3'd1, 3'd2, 3'd0, 11'h7FD, 1'b1, 1'b0);
      addr_load = 1'b1;
      addr_in   = 16'hFFFF;
      in_valid  = 1'b1;
      #1;
      chk("load_ready_low", {15'd0, in_ready}, 16'd0);
      tick();
      addr_load = 1'b0;
      in_valid  = 1'b0;
      chk("load_noaccept", {15'd0, mem_write}, 16'd0);
      chk("load_addr", mem_address, 16'hFFFE);
      offer(OP_ADD, 3'd1, 3'd2, 3'd0, 11'h7FD, 1'b1, 1'b0);
      respond(5, 16'hFFFE, 16'h12BD);
      chk("wrap_addr", mem_address, 16'h0000);
      offer(OP_NOT, 3'd3, 3'd4, 3'd0, 11'h000, 1'b0, 1'b0);
      addr_load = 1'b1;
      addr_in   = 16'h1234;
      respond(5, 16'h0000, 16'h973F);
      addr_load = 1'b0;
      chk("wrap_addr2", mem_address, 16'h0002);
      chk("wrap_count", word_count, exp_cnt + 16'd2);

      // Asynchronous reset in the middle of a write
      offer(OP_ADD, 3'd1, 3'd2, 3'd0, 11'h7FD, 1'b1, 1'b0);
      chk("mid_write", {15'd0, mem_write}, 16'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_write", {15'd0, mem_write}, 16'd0);
      chk("arst_be", {14'd0, mem_byte_enable}, 16'd0);
      #2 rst_n = 1'b1;
      tick();
      chk("arst_addr", mem_address, 16'h0000);
      chk("arst_ready", {15'd0, in_ready}, 16'd1);
      chk("arst_count", word_count, 16'h0000);
      chk("arst_wdata", mem_wdata, 16'h0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
